// File: rtl/mux_ctrl_pkg.sv
// Shared control definitions for the mux21 select path: arbiter state
// encoding and the select values that steer mux21.S.
package mux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam logic SEL_D1 = 1'b0;
  localparam logic SEL_D2 = 1'b1;

endpackage

// File: rtl/mux21_sel_arbiter.sv
// Round-robin, break-before-make arbiter driving the mux21 select, with a
// one-cycle dead gap between owners and hold-time preemption.
module mux21_sel_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter  int HOLD_MAX = 8,
  localparam int CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  output logic sel,
  output logic gnt1,
  output logic gnt2,
  output logic busy,
  output logic preempt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             last2, last2_nxt;
  logic             sel_nxt, gnt1_nxt, gnt2_nxt, preempt_nxt;
  logic             own_req, other_req, hold_expired;

  assign own_req      = (state == G2) ? req2 : req1;
  assign other_req    = (state == G2) ? req1 : req2;
  assign hold_expired = (hold_cnt == CNT_LAST) && other_req;

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    gnt1_nxt    = 1'b0;
    gnt2_nxt    = 1'b0;
    preempt_nxt = 1'b0;
    last2_nxt   = last2;
    case (state)
      IDLE, GAP: begin
        // On contention the requester that did not own the mux last wins
        if (req1 && (!req2 || last2)) begin
          state_nxt = G1;
          gnt1_nxt  = 1'b1;
          sel_nxt   = SEL_D1;
          last2_nxt = 1'b0;
        end else if (req2) begin
          state_nxt = G2;
          gnt2_nxt  = 1'b1;
          sel_nxt   = SEL_D2;
          last2_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      G1, G2: begin
        // A release wins over a coincident timeout, so preempt stays low
        if (!own_req) begin
          state_nxt = GAP;
        end else if (hold_expired) begin
          state_nxt   = GAP;
          preempt_nxt = 1'b1;
        end else begin
          gnt1_nxt = (state == G1);
          gnt2_nxt = (state == G2);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= SEL_D1;
      gnt1    <= 1'b0;
      gnt2    <= 1'b0;
      busy    <= 1'b0;
      preempt <= 1'b0;
      last2   <= 1'b1;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      gnt1    <= gnt1_nxt;
      gnt2    <= gnt2_nxt;
      busy    <= gnt1_nxt | gnt2_nxt;
      preempt <= preempt_nxt;
      last2   <= last2_nxt;
    end
  end

  // Counts cycles of the current ownership; cleared whenever no grant continues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if ((state == G1 || state == G2) && state_nxt == state) begin
      if (hold_cnt != CNT_SAT) hold_cnt <= hold_cnt + CNT_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

endmodule
